// File: rtl/hyperram_wdata_tx_pkg.sv
// Shared types and defaults for the HyperRAM write-data transmit path.
//   ST_*   : write-data phase FSM states
//   HB_DW  : HyperBus DQ pad width default
//   CNT_W  : burst word counter width
package hyperram_wdata_tx_pkg;

    localparam int unsigned HB_DW = 8;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_POST = 2'd3
    } state_t;

endpackage

// File: rtl/hyperram_oddr.sv
// Thin ODDRX1F-style wrapper: D0 is driven while SCLK is high, D1 while it is low,
// both captured on the rising SCLK edge. RST is active-high and asynchronous.
//   d0, d1 : data for the rising / falling half of the cycle
//   sclk   : ODDR clock
//   rst    : asynchronous reset, clears both capture registers
//   q      : pad output
module hyperram_oddr (
    input  logic d0,
    input  logic d1,
    input  logic sclk,
    input  logic rst,
    output logic q
);

    logic q0;
    logic q1;

    // Capture both halves on the rising edge.
    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            q0 <= 1'b0;
            q1 <= 1'b0;
        end else begin
            q0 <= d0;
            q1 <= d1;
        end
    end

    assign q = sclk ? q0 : q1;

endmodule

// File: rtl/hyperram_wdata_tx.sv
// HyperRAM write-data transmit path. Buffers 16-bit write words in a small FIFO and,
// during the write-data phase, serialises one word per clk onto DQ through ODDR cells
// (upper byte on the rising half, lower byte on the falling half) with per-byte RWDS masks.
// Ports:
//   clk, rst_n            : clock (also ODDR SCLK), async active-low reset
//   start, burst_len      : begin a phase of burst_len words (0 = empty burst)
//   abort                 : terminate PRE/DATA early, flushing the FIFO
//   s_valid/s_data/s_mask : write-word push interface, s_ready = FIFO not full
//   busy, done, underrun  : phase status; underrun is sticky until next start
//   dq_o, dq_oe           : DQ pads and output enable
//   rwds_o, rwds_oe       : RWDS pad and output enable
module hyperram_wdata_tx
    import hyperram_wdata_tx_pkg::*;
#(
    parameter int unsigned DW    = HB_DW,
    parameter int unsigned DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [CNT_W-1:0]    burst_len,
    input  logic                abort,
    input  logic                s_valid,
    input  logic [2*DW-1:0]     s_data,
    input  logic [1:0]          s_mask,
    output logic                s_ready,
    output logic                busy,
    output logic                done,
    output logic                underrun,
    output logic [DW-1:0]       dq_o,
    output logic                dq_oe,
    output logic                rwds_o,
    output logic                rwds_oe
);

    localparam int unsigned WW = 2 * DW;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned EW = WW + 2;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_next;
    logic [PW-1:0]    rd_ptr_next;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;

    logic             push;
    logic             pop;
    logic             flush;
    logic             filler;
    logic             empty;
    logic             full_next;
    logic             set_udr;
    logic             clr_udr;
    logic             oe_next;

    logic [DW-1:0]    oddr_d0;
    logic [DW-1:0]    oddr_d1;
    logic             oddr_rwds0;
    logic             oddr_rwds1;
    logic [DW-1:0]    d0_next;
    logic [DW-1:0]    d1_next;
    logic             rwds0_next;
    logic             rwds1_next;
    logic             oddr_rst;

    // FIFO bookkeeping; a flush also swallows a word pushed in the same cycle.
    assign push        = s_valid && s_ready;
    assign empty       = (wr_ptr == rd_ptr);
    assign head        = mem[rd_ptr[AW-1:0]];
    assign wr_ptr_next = wr_ptr + PW'(push);
    assign rd_ptr_next = flush ? wr_ptr_next : (rd_ptr + PW'(pop));
    assign full_next   = (wr_ptr_next[PW-1] != rd_ptr_next[PW-1]) &&
                         (wr_ptr_next[AW-1:0] == rd_ptr_next[AW-1:0]);

    // FIFO storage, entry = {mask, data}.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {s_mask, s_data};
        end
    end

    // State, counter, pointers and registered status.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            s_ready  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
            dq_oe    <= 1'b0;
            rwds_oe  <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            wr_ptr   <= wr_ptr_next;
            rd_ptr   <= rd_ptr_next;
            s_ready  <= !full_next;
            busy     <= (state_next != ST_IDLE);
            done     <= (state_next == ST_POST);
            if (clr_udr) begin
                underrun <= 1'b0;
            end else if (set_udr) begin
                underrun <= 1'b1;
            end
            dq_oe    <= oe_next;
            rwds_oe  <= oe_next;
        end
    end

    // Next-state, pop/filler decisions.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pop        = 1'b0;
        flush      = 1'b0;
        filler     = 1'b0;
        set_udr    = 1'b0;
        clr_udr    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    cnt_next   = burst_len;
                    clr_udr    = 1'b1;
                    state_next = (burst_len == '0) ? ST_POST : ST_PRE;
                end
            end
            ST_PRE: begin
                if (abort) begin
                    flush      = 1'b1;
                    state_next = ST_POST;
                end else begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                // An empty FIFO yields a fully masked filler word; the burst never stalls.
                if (empty) begin
                    filler  = 1'b1;
                    set_udr = 1'b1;
                end else begin
                    pop = 1'b1;
                end
                cnt_next = cnt - CNT_W'(1);
                if (abort) begin
                    flush      = 1'b1;
                    state_next = ST_POST;
                end else if (cnt == CNT_W'(1)) begin
                    state_next = ST_POST;
                end
            end
            ST_POST: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Pads are driven for PRE, DATA and the POST of a non-empty burst only.
    assign oe_next = (state_next == ST_PRE) || (state_next == ST_DATA) ||
                     ((state_next == ST_POST) && (state != ST_IDLE));

    // ODDR input staging: the word popped this cycle is presented next cycle.
    always_comb begin
        d0_next    = '0;
        d1_next    = '0;
        rwds0_next = 1'b0;
        rwds1_next = 1'b0;
        if (pop) begin
            {rwds0_next, rwds1_next, d0_next, d1_next} = head;
        end else if (filler) begin
            rwds0_next = 1'b1;
            rwds1_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oddr_d0    <= '0;
            oddr_d1    <= '0;
            oddr_rwds0 <= 1'b0;
            oddr_rwds1 <= 1'b0;
        end else begin
            oddr_d0    <= d0_next;
            oddr_d1    <= d1_next;
            oddr_rwds0 <= rwds0_next;
            oddr_rwds1 <= rwds1_next;
        end
    end

    assign oddr_rst = ~rst_n;

    // One ODDR per DQ bit plus one for RWDS.
    for (genvar i = 0; i < DW; i++) begin : g_dq
        hyperram_oddr u_oddr (
            .d0   (oddr_d0[i]),
            .d1   (oddr_d1[i]),
            .sclk (clk),
            .rst  (oddr_rst),
            .q    (dq_o[i])
        );
    end

    hyperram_oddr u_oddr_rwds (
        .d0   (oddr_rwds0),
        .d1   (oddr_rwds1),
        .sclk (clk),
        .rst  (oddr_rst),
        .q    (rwds_o)
    );

endmodule

// File: tb/tb_hyperram_wdata_tx.sv
// Self-checking bench for hyperram_wdata_tx: directed vector table, hand-written
// corner sequences (full FIFO, abort, mid-burst reset) and randomized bursts checked
// against a queue-based model of the FIFO and the burst timeline.
module tb_hyperram_wdata_tx;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [7:0]      burst_len;
    logic            abort;
    logic            s_valid;
    logic [15:0]     s_data;
    logic [1:0]      s_mask;
    logic            s_ready;
    logic            busy;
    logic            done;
    logic            underrun;
    logic [DW-1:0]   dq_o;
    logic            dq_oe;
    logic            rwds_o;
    logic            rwds_oe;

    int unsigned errors = 0;
    int unsigned checks = 0;

    // Model FIFO contents, entry = {mask, data}.
    logic [17:0] q [$];

    hyperram_wdata_tx #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .burst_len (burst_len),
        .abort     (abort),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_mask    (s_mask),
        .s_ready   (s_ready),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun),
        .dq_o      (dq_o),
        .dq_oe     (dq_oe),
        .rwds_o    (rwds_o),
        .rwds_oe   (rwds_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned nw;
        logic [15:0] w0;
        logic [1:0]  m0;
        logic [15:0] w1;
        logic [1:0]  m1;
        int unsigned len;
        logic        exp_udr;
        int unsigned exp_done;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w, input logic [1:0] m);
        int unsigned t = 0;
        while (!s_ready && t < 50) begin
            step();
            t++;
        end
        if (!s_ready) chk("push_wait_timeout", 32'(s_ready), 32'd1);
        s_valid = 1'b1;
        s_data  = w;
        s_mask  = m;
        step();
        s_valid = 1'b0;
        q.push_back({m, w});
        chk("s_ready_after_push", 32'(s_ready), 32'(q.size() < DEPTH));
    endtask

    // Runs one write-data phase from the current cycle and checks every cycle of it.
    task automatic run_burst(input int unsigned len, input int unsigned abort_at,
                             output int unsigned done_cyc);
        int unsigned n0 = q.size();
        int unsigned eff;
        int unsigned post;
        int unsigned i;
        logic [17:0] e;
        logic [17:0] stream [$];
        eff  = (abort_at != 0 && abort_at < len) ? abort_at : len;
        post = (len == 0) ? 1 : eff + 2;
        done_cyc = 99;
        for (int unsigned k = 0; k <= post + 2; k++) begin
            e = '0;
            if (len != 0 && k >= 3 && k <= eff + 2) begin
                i = k - 3;
                e = (i < n0) ? q[i] : {2'b11, 16'h0000};
            end
            stream.push_back(e);
        end
        start     = 1'b1;
        burst_len = 8'(len);
        for (int unsigned k = 0; k <= post + 2; k++) begin
            if (done === 1'b1 && done_cyc == 99) done_cyc = k;
            chk("oddr_d0",    32'(dut.oddr_d0),    32'(stream[k][15:8]));
            chk("oddr_d1",    32'(dut.oddr_d1),    32'(stream[k][7:0]));
            chk("oddr_rwds0", 32'(dut.oddr_rwds0), 32'(stream[k][17]));
            chk("oddr_rwds1", 32'(dut.oddr_rwds1), 32'(stream[k][16]));
            if (k >= 1) begin
                chk("pad_dq_rise",   32'(dq_o),   32'(stream[k-1][15:8]));
                chk("pad_rwds_rise", 32'(rwds_o), 32'(stream[k-1][17]));
            end
            chk("busy",    32'(busy),    32'(k >= 1 && k <= post));
            chk("done",    32'(done),    32'(k == post));
            chk("dq_oe",   32'(dq_oe),   32'(len != 0 && k >= 1 && k <= post));
            chk("rwds_oe", 32'(rwds_oe), 32'(len != 0 && k >= 1 && k <= post));
            if (k == 1) chk("underrun_cleared", 32'(underrun), 32'd0);
            abort = (abort_at != 0 && len != 0 && k == eff + 1);
            step();
            start = 1'b0;
        end
        abort = 1'b0;
        chk("underrun_end", 32'(underrun), 32'(len != 0 && eff > n0));
        for (int unsigned j = 0; j < eff && q.size() > 0; j++) void'(q.pop_front());
        if (abort_at != 0 && len != 0) q.delete();
    endtask

    initial begin
        vec_t        vecs [4];
        int unsigned dc;
        int unsigned len;
        int unsigned ab;
        int unsigned n;

        vecs[0] = '{nw: 2, w0: 16'hA1B2, m0: 2'b00, w1: 16'hC3D4, m1: 2'b00, len: 2, exp_udr: 1'b0, exp_done: 4};
        vecs[1] = '{nw: 1, w0: 16'h5566, m0: 2'b10, w1: 16'h0000, m1: 2'b00, len: 1, exp_udr: 1'b0, exp_done: 3};
        vecs[2] = '{nw: 1, w0: 16'h789A, m0: 2'b01, w1: 16'h0000, m1: 2'b00, len: 3, exp_udr: 1'b1, exp_done: 5};
        vecs[3] = '{nw: 0, w0: 16'h0000, m0: 2'b00, w1: 16'h0000, m1: 2'b00, len: 0, exp_udr: 1'b0, exp_done: 1};

        rst_n = 1'b0; start = 1'b0; burst_len = '0; abort = 1'b0;
        s_valid = 1'b0; s_data = '0; s_mask = '0;
        #12;
        chk("rst_s_ready",  32'(s_ready),  32'd1);
        chk("rst_busy",     32'(busy),     32'd0);
        chk("rst_done",     32'(done),     32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        chk("rst_dq_oe",    32'(dq_oe),    32'd0);
        chk("rst_rwds_oe",  32'(rwds_oe),  32'd0);
        chk("rst_oddr_d0",  32'(dut.oddr_d0), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Directed vector table.
        for (int v = 0; v < 4; v++) begin
            if (vecs[v].nw >= 1) push_word(vecs[v].w0, vecs[v].m0);
            if (vecs[v].nw >= 2) push_word(vecs[v].w1, vecs[v].m1);
            run_burst(vecs[v].len, 0, dc);
            chk("vec_done_cycle", 32'(dc),       32'(vecs[v].exp_done));
            chk("vec_underrun",   32'(underrun), 32'(vecs[v].exp_udr));
        end

        // FIFO fill: DEPTH+1 back-to-back pushes; the last is held until a pop frees space.
        s_valid = 1'b1;
        s_mask  = 2'b00;
        for (int unsigned i = 0; i <= DEPTH; i++) begin
            s_data = 16'(16'h1000 + i);
            chk("fill_s_ready", 32'(s_ready), 32'(i < DEPTH));
            if (i < DEPTH) q.push_back({2'b00, 16'(16'h1000 + i)});
            step();
        end
        chk("full_hold_s_ready", 32'(s_ready), 32'd0);
        run_burst(1, 0, dc);
        s_valid = 1'b0;
        q.push_back({2'b00, 16'(16'h1000 + DEPTH)});
        chk("refull_s_ready", 32'(s_ready), 32'd0);
        run_burst(DEPTH, 0, dc);
        chk("drained_s_ready", 32'(s_ready), 32'd1);

        // Abort on the 3rd DATA cycle of a len=8 burst with a full FIFO.
        for (int unsigned i = 0; i < DEPTH; i++) push_word(16'(16'h2000 + i), 2'(i));
        run_burst(8, 3, dc);
        chk("abort_done_cycle", 32'(dc), 32'd5);
        chk("abort_s_ready",    32'(s_ready), 32'd1);
        run_burst(1, 0, dc);

        // Randomized bursts against the model.
        for (int r = 0; r < 25; r++) begin
            n = $urandom_range(0, DEPTH - q.size());
            for (int unsigned i = 0; i < n; i++) push_word(16'($urandom), 2'($urandom));
            len = $urandom_range(0, 6);
            ab  = 0;
            if (len != 0 && ($urandom % 4) == 0) ab = $urandom_range(1, len);
            run_burst(len, ab, dc);
            chk("rand_done_cycle", 32'(dc),
                32'((len == 0) ? 1 : (((ab != 0) ? ab : len) + 2)));
        end

        // Reset in the middle of DATA.
        push_word(16'h3344, 2'b00);
        push_word(16'h5566, 2'b00);
        start = 1'b1;
        burst_len = 8'd4;
        step();
        start = 1'b0;
        step();
        step();
        chk("pre_reset_dq_oe", 32'(dq_oe), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dq_oe",   32'(dq_oe),   32'd0);
        chk("mid_rst_rwds_oe", 32'(rwds_oe), 32'd0);
        chk("mid_rst_busy",    32'(busy),    32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("mid_rst_no_done", 32'(done), 32'd0);
        end
        rst_n = 1'b1;
        q.delete();
        step();
        chk("post_rst_s_ready", 32'(s_ready), 32'd1);
        chk("post_rst_done",    32'(done),    32'd0);
        run_burst(0, 0, dc);
        chk("post_rst_len0_done", 32'(dc), 32'd1);
        run_burst(1, 0, dc);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
